// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state encoding, button
// indices and the default debounce length.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int DB_CYCLES_DEF = 65535;
  localparam int NUM_BTN       = 2;
  localparam int BTN_START     = 0;
  localparam int BTN_PAUSE     = 1;

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 65535
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_diff;
  logic          w_flip;

  assign w_diff  = r_sync[1] ^ r_level;
  // the DB_CYCLES-th consecutive mismatching cycle commits the new level
  assign w_flip  = w_diff && (r_cnt == LAST);
  assign o_press = r_press;

  // synchronize, count consecutive mismatches, flip level and emit press
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= w_flip && r_sync[1];
      if (w_flip) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow sequencer: debounced start/pause buttons drive an
// IDLE/PLAY/PAUSE/OVER machine that gates the animate pulse and counts
// animated frames. Pause changes take effect only at end of frame.
module game_sequencer
  import game_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int FRAME_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_collide,
  input  logic               i_animate,
  input  logic               i_screenend,
  output logic [1:0]         o_state,
  output logic               o_paused,
  output logic               o_anim_tick,
  output logic               o_timing_rst,
  output logic [FRAME_W-1:0] o_frame
);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_press;

  state_t             r_state;
  logic               r_pend;
  logic               r_timing_rst;
  logic [FRAME_W-1:0] r_frame;

  assign w_raw[BTN_START] = i_start;
  assign w_raw[BTN_PAUSE] = i_pause;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (w_raw[g]),
      .o_press (w_press[g])
    );
  end

  assign o_state      = r_state;
  assign o_paused     = (r_state == ST_PAUSE);
  assign o_anim_tick  = i_animate && (r_state == ST_PLAY);
  assign o_timing_rst = r_timing_rst;
  assign o_frame      = r_frame;

  // state machine, pending-pause flag, restart pulse and frame counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_pend       <= 1'b0;
      r_timing_rst <= 1'b0;
      r_frame      <= '0;
    end else begin
      r_timing_rst <= 1'b0;
      if (o_anim_tick) r_frame <= r_frame + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_press[BTN_START]) begin
            r_state      <= ST_PLAY;
            r_timing_rst <= 1'b1;
            r_frame      <= '0;
            r_pend       <= 1'b0;
          end
        end
        ST_PLAY: begin
          // collision wins over a pause due at this same frame end
          if (i_collide) begin
            r_state <= ST_OVER;
            r_pend  <= 1'b0;
          end else if (i_screenend && r_pend) begin
            r_state <= ST_PAUSE;
            r_pend  <= 1'b0;
          end else if (w_press[BTN_PAUSE]) begin
            r_pend  <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (i_screenend && r_pend) begin
            r_state <= ST_PLAY;
            r_pend  <= 1'b0;
          end else if (w_press[BTN_PAUSE]) begin
            r_pend  <= 1'b1;
          end
        end
        ST_OVER: begin
          if (w_press[BTN_START]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with DB_CYCLES=4. A second instance with
// FRAME_W=4 shares all inputs to observe frame-counter wrap.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, pause, collide, animate, screenend;
  logic [1:0]  state, state4;
  logic        paused, paused4, atick, atick4, trst, trst4;
  logic [15:0] frame;
  logic [3:0]  frame4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_sequencer #(.DB_CYCLES(4), .FRAME_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause),
    .i_collide(collide), .i_animate(animate), .i_screenend(screenend),
    .o_state(state), .o_paused(paused), .o_anim_tick(atick),
    .o_timing_rst(trst), .o_frame(frame)
  );

  game_sequencer #(.DB_CYCLES(4), .FRAME_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause),
    .i_collide(collide), .i_animate(animate), .i_screenend(screenend),
    .o_state(state4), .o_paused(paused4), .o_anim_tick(atick4),
    .o_timing_rst(trst4), .o_frame(frame4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // hold a button 8 cycles (press fires on the 6th) then release 8 cycles
  task automatic press_pause();
    pause = 1'b1; ticks(8);
    pause = 1'b0; ticks(8);
  endtask

  task automatic press_start();
    start = 1'b1; ticks(8);
    start = 1'b0; ticks(8);
  endtask

  task automatic end_frame();
    screenend = 1'b1; tick();
    screenend = 1'b0;
  endtask

  // n animate pulses; returns how many cycles showed o_anim_tick
  task automatic animate_n(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      animate = 1'b1; #1;
      seen += int'(atick);
      tick();
      animate = 1'b0; tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; pause = 0; collide = 0; animate = 0; screenend = 0;
    ticks(3);
    animate = 1'b1; #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (frame !== 16'd0) begin errors++; $display("FAIL rst_frame got=%0d exp=0", frame); end
    checks++; if (trst !== 1'b0 || paused !== 1'b0) begin errors++; $display("FAIL rst_outs trst=%b paused=%b exp=0,0", trst, paused); end
    checks++; if (atick !== 1'b0) begin errors++; $display("FAIL rst_atick got=%b exp=0", atick); end
    animate = 1'b0;
    rst_n = 1'b1; tick();
  endtask

  task automatic test_short_press();
    int not_idle = 0;
    start = 1'b1; ticks(3);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (state !== 2'd0) not_idle++; end
    checks++; if (not_idle !== 0) begin errors++; $display("FAIL short_press non_idle_cycles=%0d exp=0", not_idle); end
  endtask

  task automatic test_start();
    int first = -1, rst_cnt = 0;
    logic rst_at_first = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) start = 1'b0;
      tick();
      rst_cnt += int'(trst);
      if (first < 0 && state === 2'd1) begin first = i; rst_at_first = trst; end
    end
    checks++; if (first !== 7) begin errors++; $display("FAIL start_latency got=%0d exp=7", first); end
    checks++; if (rst_at_first !== 1'b1 || rst_cnt !== 1) begin errors++; $display("FAIL start_trst at_entry=%b count=%0d exp=1,1", rst_at_first, rst_cnt); end
    checks++; if (frame !== 16'd0) begin errors++; $display("FAIL start_frame got=%0d exp=0", frame); end
  endtask

  task automatic test_play_pause();
    int seen;
    animate_n(5, seen);
    checks++; if (seen !== 5) begin errors++; $display("FAIL play_ticks got=%0d exp=5", seen); end
    checks++; if (frame !== 16'd5) begin errors++; $display("FAIL play_frame got=%0d exp=5", frame); end
    press_pause();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL pause_wait_state got=%0d exp=1", state); end
    end_frame();
    checks++; if (state !== 2'd2 || paused !== 1'b1) begin errors++; $display("FAIL pause_enter state=%0d paused=%b exp=2,1", state, paused); end
  endtask

  task automatic test_in_pause();
    int seen;
    animate_n(3, seen);
    checks++; if (seen !== 0 || frame !== 16'd5) begin errors++; $display("FAIL pause_hold ticks=%0d frame=%0d exp=0,5", seen, frame); end
    collide = 1'b1; tick(); collide = 1'b0;
    end_frame();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_collide_ignored got=%0d exp=2", state); end
    press_start();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_start_ignored got=%0d exp=2", state); end
    press_pause();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL resume_wait got=%0d exp=2", state); end
    end_frame();
    checks++; if (state !== 2'd1 || paused !== 1'b0) begin errors++; $display("FAIL resume state=%0d paused=%b exp=1,0", state, paused); end
  endtask

  task automatic test_collide();
    press_pause();
    screenend = 1'b1; collide = 1'b1; tick();
    screenend = 1'b0; collide = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL collide_over got=%0d exp=3", state); end
    press_pause(); end_frame();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL over_hold got=%0d exp=3", state); end
    press_start();
    checks++; if (state !== 2'd0 || frame !== 16'd5) begin errors++; $display("FAIL over_to_idle state=%0d frame=%0d exp=0,5", state, frame); end
  endtask

  task automatic test_wrap();
    int seen;
    press_start();
    checks++; if (state !== 2'd1 || state4 !== 2'd1 || frame4 !== 4'd0) begin errors++; $display("FAIL wrap_start state=%0d state4=%0d frame4=%0d exp=1,1,0", state, state4, frame4); end
    animate_n(17, seen);
    checks++; if (frame4 !== 4'd1 || frame !== 16'd17) begin errors++; $display("FAIL wrap frame4=%0d frame=%0d exp=1,17", frame4, frame); end
  endtask

  task automatic test_double_pause();
    press_pause(); press_pause();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL dbl_pause_wait got=%0d exp=1", state); end
    end_frame();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL dbl_pause_enter got=%0d exp=2", state); end
  endtask

  task automatic test_reset_mid_pause();
    int rst_cnt = 0;
    press_pause();
    rst_n = 1'b0; tick();
    rst_cnt += int'(trst);
    checks++; if (state !== 2'd0 || frame !== 16'd0) begin errors++; $display("FAIL midrst state=%0d frame=%0d exp=0,0", state, frame); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); rst_cnt += int'(trst); end
    end_frame(); rst_cnt += int'(trst);
    checks++; if (rst_cnt !== 0 || state !== 2'd0) begin errors++; $display("FAIL midrst_after trst_cnt=%0d state=%0d exp=0,0", rst_cnt, state); end
  endtask

  task automatic test_held_through_reset();
    start = 1'b1; rst_n = 1'b0; ticks(3);
    rst_n = 1'b1;
    ticks(6);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL held_early got=%0d exp=0", state); end
    tick();
    checks++; if (state !== 2'd1 || trst !== 1'b1) begin errors++; $display("FAIL held_press state=%0d trst=%b exp=1,1", state, trst); end
    start = 1'b0; ticks(8);
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_start();
    test_play_pause();
    test_in_pause();
    test_collide();
    test_wrap();
    test_double_pause();
    test_reset_mid_pause();
    test_held_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
